// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin sharing of the single genrom read port between
// instruction fetch (port 0) and data load (port 1), with per-port bounds windows.
module rom_arbiter #(
    parameter  int MEM_ADDR  = 5,
    parameter  int MEM_EXTRA = 4,
    localparam int AW        = MEM_ADDR + 1,
    localparam int DW        = (2 ** MEM_EXTRA) * 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [AW-1:0]        addr0,
    input  logic [AW-1:0]        addr1,
    input  logic [MEM_EXTRA-1:0] extra0,
    input  logic [MEM_EXTRA-1:0] extra1,
    output logic                 valid0,
    output logic                 valid1,
    output logic [DW-1:0]        data0,
    output logic [DW-1:0]        data1,
    output logic                 err0,
    output logic                 err1,
    output logic                 busy,
    input  logic                 cfg_we,
    input  logic                 cfg_sel,
    input  logic [AW-1:0]        cfg_lower,
    input  logic [AW-1:0]        cfg_upper,
    output logic [AW-1:0]        mem_addr,
    output logic [MEM_EXTRA-1:0] mem_extra,
    output logic [AW-1:0]        mem_lower_bound,
    output logic [AW-1:0]        mem_upper_bound,
    input  logic [DW-1:0]        mem_data,
    input  logic                 mem_error
);
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t        state, state_next;
    logic          owner, last;
    logic          grant, win;
    logic [AW-1:0] lo0, up0, lo1, up1;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Ties go to the port that was not served last.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        win        = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant      = 1'b1;
                    win        = (req0 && req1) ? ~last : req1;
                    state_next = ISSUE;
                end
            end
            ISSUE:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            owner           <= 1'b0;
            last            <= 1'b1;
            valid0          <= 1'b0;
            valid1          <= 1'b0;
            data0           <= '0;
            data1           <= '0;
            err0            <= 1'b0;
            err1            <= 1'b0;
            mem_addr        <= '0;
            mem_extra       <= '0;
            mem_lower_bound <= '0;
            mem_upper_bound <= '1;
            lo0             <= '0;
            up0             <= '1;
            lo1             <= '0;
            up1             <= '1;
        end else begin
            valid0 <= 1'b0;
            valid1 <= 1'b0;
            if (cfg_we) begin
                if (cfg_sel) begin
                    lo1 <= cfg_lower;
                    up1 <= cfg_upper;
                end else begin
                    lo0 <= cfg_lower;
                    up0 <= cfg_upper;
                end
            end
            // Bounds are sampled before any same-edge config write lands.
            if (grant) begin
                owner           <= win;
                mem_addr        <= win ? addr1  : addr0;
                mem_extra       <= win ? extra1 : extra0;
                mem_lower_bound <= win ? lo1    : lo0;
                mem_upper_bound <= win ? up1    : up0;
            end
            if (state == DONE) begin
                last <= owner;
                if (owner) begin
                    data1  <= mem_data;
                    err1   <= mem_error;
                    valid1 <= 1'b1;
                end else begin
                    data0  <= mem_data;
                    err0   <= mem_error;
                    valid0 <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: behavioural genrom plus a transaction-level model of
// grant order, latency, data and bounds errors.
module tb_rom_arbiter;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [5:0]   addr0 = '0, addr1 = '0;
    logic [3:0]   extra0 = '0, extra1 = '0;
    logic         valid0, valid1;
    logic [127:0] data0, data1;
    logic         err0, err1, busy;
    logic         cfg_we = 1'b0, cfg_sel = 1'b0;
    logic [5:0]   cfg_lower = '0, cfg_upper = '0;
    logic [5:0]   mem_addr, mem_lower_bound, mem_upper_bound;
    logic [3:0]   mem_extra;
    logic [127:0] mem_data = '0;
    logic         mem_error = 1'b0;

    int checks = 0;
    int errors = 0;

    // reference state: bounds per port and the round-robin pointer
    logic [5:0] blo [2];
    logic [5:0] bup [2];
    logic       rr_last;

    rom_arbiter #(.MEM_ADDR(5), .MEM_EXTRA(4)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .extra0(extra0), .extra1(extra1),
        .valid0(valid0), .valid1(valid1), .data0(data0), .data1(data1),
        .err0(err0), .err1(err1), .busy(busy),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_lower(cfg_lower), .cfg_upper(cfg_upper),
        .mem_addr(mem_addr), .mem_extra(mem_extra),
        .mem_lower_bound(mem_lower_bound), .mem_upper_bound(mem_upper_bound),
        .mem_data(mem_data), .mem_error(mem_error)
    );

    always #5 clk = ~clk;

    // ROM content: byte at address a is a; extra selects how many further bytes follow
    function automatic logic [127:0] rom_bytes(input logic [5:0] a, input logic [3:0] x);
        logic [127:0] d;
        d = '0;
        for (int i = 0; i < 16; i++)
            if (i <= int'(x)) d[8*i +: 8] = 8'(int'(a) + i);
        return d;
    endfunction

    function automatic logic rom_fault(input logic [5:0] a, input logic [3:0] x,
                                       input logic [5:0] lo, input logic [5:0] up);
        return (int'(a) < int'(lo)) || (int'(a) + int'(x) > int'(up));
    endfunction

    always @(posedge clk) begin
        mem_data  <= rom_bytes(mem_addr, mem_extra);
        mem_error <= rom_fault(mem_addr, mem_extra, mem_lower_bound, mem_upper_bound);
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; cfg_we = 1'b0;
        tick(); tick();
        reset = 1'b0;
        blo[0] = '0; blo[1] = '0; bup[0] = '1; bup[1] = '1;
        rr_last = 1'b1;
    endtask

    // Waits up to limit cycles for a strobe; port = -1 when none arrives.
    task automatic wait_strobe(input int limit, output int port, output int n);
        port = -1; n = 0;
        while (port < 0 && n < limit) begin
            tick(); n++;
            if (valid0 || valid1) begin
                chk("strobe_exclusive", {127'b0, valid0 & valid1}, '0);
                port = valid1 ? 1 : 0;
            end
        end
    endtask

    // Raise the selected requests and serve each once, checking order, timing and data.
    task automatic do_reqs(input logic r0, input logic r1, input string tag);
        int p, n, t, served;
        logic exp_p;
        logic [127:0] ed [2];
        logic         ee [2];
        ed[0] = rom_bytes(addr0, extra0); ee[0] = rom_fault(addr0, extra0, blo[0], bup[0]);
        ed[1] = rom_bytes(addr1, extra1); ee[1] = rom_fault(addr1, extra1, blo[1], bup[1]);
        exp_p = (r0 && r1) ? ~rr_last : r1;
        req0 = r0; req1 = r1; t = 0; served = 0;
        repeat (int'(r0) + int'(r1)) begin
            wait_strobe(8, p, n); t += n;
            chk({tag, "_port"}, 128'(p), 128'(exp_p));
            chk({tag, "_latency"}, 128'(t), 128'(3 * (served + 1)));
            if (p >= 0) begin
                chk({tag, "_data"}, p[0] ? data1 : data0, ed[p[0]]);
                chk({tag, "_err"}, 128'(p[0] ? err1 : err0), 128'(ee[p[0]]));
                if (p[0]) req1 = 1'b0; else req0 = 1'b0;
                rr_last = p[0];
            end
            served++; exp_p = ~exp_p;
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin
        int p, n;
        logic [1:0] r;

        // reset state
        do_reset();
        chk("rst_valid0", 128'(valid0), 0);
        chk("rst_valid1", 128'(valid1), 0);
        chk("rst_data0", data0, 0);
        chk("rst_data1", data1, 0);
        chk("rst_err", 128'({err0, err1}), 0);
        chk("rst_busy", 128'(busy), 0);
        chk("rst_mem_addr", 128'(mem_addr), 0);
        chk("rst_mem_extra", 128'(mem_extra), 0);
        chk("rst_mem_lower", 128'(mem_lower_bound), 0);
        chk("rst_mem_upper", 128'(mem_upper_bound), 128'(6'h3f));

        // single fetch
        addr0 = 6'd3; extra0 = 4'd0;
        do_reqs(1'b1, 1'b0, "single");
        chk("single_byte", 128'(data0[7:0]), 128'(8'h03));

        // tie: alternation starting with port 0, three cycles apart
        do_reset();
        addr0 = 6'd1; addr1 = 6'd2; extra0 = '0; extra1 = '0;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_strobe(8, p, n);
            chk("tie_order", 128'(p), 128'(k % 2));
            chk("tie_spacing", 128'(n), 128'(3));
            if (p == 1) chk("tie_data1", 128'(data1[7:0]), 128'(8'h02));
            if (p == 0) chk("tie_data0", 128'(data0[7:0]), 128'(8'h01));
            if (k == 2) req0 = 1'b0;
            if (k == 3) req1 = 1'b0;
        end

        // bounds fault on port 1 only
        do_reset();
        cfg_sel = 1'b1; cfg_lower = 6'd0; cfg_upper = 6'd7; cfg_we = 1'b1;
        tick(); cfg_we = 1'b0;
        blo[1] = 6'd0; bup[1] = 6'd7;
        addr1 = 6'd20; extra1 = '0;
        do_reqs(1'b0, 1'b1, "bnd1");
        chk("bnd1_err", 128'(err1), 1);
        addr0 = 6'd20; extra0 = '0;
        do_reqs(1'b1, 1'b0, "bnd0");
        chk("bnd0_err", 128'(err0), 0);
        chk("bnd0_byte", 128'(data0[7:0]), 128'(8'h14));

        // config write in ISSUE affects only the next grant
        do_reset();
        addr0 = 6'd10; extra0 = '0; req0 = 1'b1;
        tick();
        cfg_sel = 1'b0; cfg_lower = 6'd0; cfg_upper = 6'd3; cfg_we = 1'b1;
        tick(); cfg_we = 1'b0;
        blo[0] = 6'd0; bup[0] = 6'd3;
        wait_strobe(6, p, n);
        chk("cfgmid_port", 128'(p), 0);
        chk("cfgmid_timing", 128'(n), 1);
        chk("cfgmid_err", 128'(err0), 0);
        req0 = 1'b0; rr_last = 1'b0;
        do_reqs(1'b1, 1'b0, "cfgnext");
        chk("cfgnext_err", 128'(err0), 1);
        // config write on the grant edge: grant still uses the old window
        req0 = 1'b1; cfg_lower = 6'd0; cfg_upper = 6'd63; cfg_we = 1'b1;
        tick(); cfg_we = 1'b0;
        wait_strobe(6, p, n);
        chk("cfggrant_port", 128'(p), 0);
        chk("cfggrant_err", 128'(err0), 1);
        req0 = 1'b0; bup[0] = 6'd63;

        // reset during ISSUE discards the read
        do_reset();
        addr0 = 6'd4; extra0 = '0; req0 = 1'b1;
        tick();
        chk("rstmid_busy_before", 128'(busy), 1);
        reset = 1'b1; req0 = 1'b0;
        tick(); reset = 1'b0;
        chk("rstmid_busy", 128'(busy), 0);
        chk("rstmid_upper", 128'(mem_upper_bound), 128'(6'h3f));
        chk("rstmid_addr", 128'(mem_addr), 0);
        wait_strobe(6, p, n);
        chk("rstmid_no_valid", 128'(p), 128'(-1));
        do_reqs(1'b1, 1'b0, "rstmid_after");

        // hold rule: req1 held for two strobes, req0 arrives mid-stream
        do_reset();
        addr1 = 6'd5; addr0 = 6'd9; extra0 = '0; extra1 = '0; req1 = 1'b1;
        wait_strobe(8, p, n);
        chk("hold_first_port", 128'(p), 1);
        chk("hold_first_lat", 128'(n), 3);
        tick(); req0 = 1'b1;
        wait_strobe(8, p, n);
        chk("hold_second_port", 128'(p), 1);
        chk("hold_second_gap", 128'(n + 1), 3);
        req1 = 1'b0;
        wait_strobe(8, p, n);
        chk("hold_next_port", 128'(p), 0);
        chk("hold_next_gap", 128'(n), 3);
        chk("hold_next_byte", 128'(data0[7:0]), 128'(8'h09));
        req0 = 1'b0;
        wait_strobe(6, p, n);
        chk("hold_quiet", 128'(p), 128'(-1));

        // randomized traffic with occasional idle-time bounds updates
        do_reset();
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                cfg_sel   = 1'($urandom_range(0, 1));
                cfg_lower = 6'($urandom_range(0, 31));
                cfg_upper = 6'($urandom_range(16, 63));
                cfg_we = 1'b1;
                tick(); cfg_we = 1'b0;
                blo[cfg_sel] = cfg_lower; bup[cfg_sel] = cfg_upper;
            end
            addr0 = 6'($urandom); addr1 = 6'($urandom);
            extra0 = 4'($urandom); extra1 = 4'($urandom);
            r = 2'($urandom_range(1, 3));
            do_reqs(r[0], r[1], "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rom_arbiter.md
# rom_arbiter

Shares the single synchronous `genrom` read port between two requesters: port 0 (instruction fetch) and port 1 (data load). Each request is held until it is served. Grants are round-robin. Each port has its own `lower_bound`/`upper_bound` window, programmed through a config interface and driven to the ROM for the granted port, so the ROM's own bounds check enforces per-port protection. The block sits between `cpu` and `genrom` and replaces the direct `mem_*` connection.

## Interface
- `MEM_ADDR`, 5: ROM address MSB index; addresses are `MEM_ADDR+1` bits.
- `MEM_EXTRA`, 4: width of `extra`; data width `DW = 2**MEM_EXTRA*8`.
- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `req0`, `req1`  in  1  request, held high with stable addr/extra until matching `valid`.
- `addr0`, `addr1`  in  MEM_ADDR+1  byte address.
- `extra0`, `extra1`  in  MEM_EXTRA  extra-bytes field, passed to ROM.
- `valid0`, `valid1`  out  1  one-cycle response strobe.
- `data0`, `data1`  out  DW  response data, held until that port's next response.
- `err0`, `err1`  out  1  ROM error for that response, qualified by `valid`.
- `busy`  out  1  high in any state except IDLE.
- `cfg_we`  in  1  write bounds for port `cfg_sel`.
- `cfg_sel`  in  1  target port.
- `cfg_lower`, `cfg_upper`  in  MEM_ADDR+1  bounds values.
- `mem_addr`  out  MEM_ADDR+1  to ROM `addr`.
- `mem_extra`  out  MEM_EXTRA  to ROM `extra`.
- `mem_lower_bound`, `mem_upper_bound`  out  MEM_ADDR+1  to ROM bounds.
- `mem_data`  in  DW  from ROM, valid one cycle after the address is sampled.
- `mem_error`  in  1  from ROM, same timing as `mem_data`.

## Operation
- **FSM states:** IDLE → ISSUE → DONE → IDLE.
- **IDLE:** on an edge with any `req` high, pick the winner and register the following: `owner`; `mem_addr`/`mem_extra` from the winner; `mem_*_bound` from the winner's bound registers. Go to ISSUE.
- **Arbitration:** if one port requests, it wins. If both request, the port not granted last wins. The `last` pointer resets to 1, so port 0 wins the first tie.
- **ISSUE:** the ROM samples the address at this edge. Go to DONE.
- **DONE:** capture `mem_data`/`mem_error` into `data<owner>`/`err<owner>`, pulse `valid<owner>`, set `last=owner`, go to IDLE. Requests are ignored during DONE.
- **Requester rule:** drop `req` in the cycle `valid` is high, or keep it high to issue a new request. The bench must drop it unless a new read is intended.
- **Bound registers:** `lo0`, `up0`, `lo1`, `up1`.
  - Reset values: lo = 0, up = all-ones.
  - `cfg_we` writes the `cfg_sel` pair at the edge.
  - Bounds are latched into `mem_*_bound` only at grant, so a config write mid-transaction affects only later grants.
  - A config write in the same cycle as an IDLE grant to the same port: the grant uses the old values.
- `mem_*` outputs hold their values after DONE until the next grant.

## Timing
- **Reset values:** `valid*` 0, `data*` 0, `err*` 0, `busy` 0, `mem_addr` 0, `mem_extra` 0, `mem_lower_bound` 0, `mem_upper_bound` all-ones, state IDLE, `last` 1.
- **Latency:** `req` first sampled high at edge N (IDLE) → `mem_addr` valid after N → ROM samples at N+1 → `valid` high during the cycle after N+2. Request-to-strobe is 3 edges.
- **Throughput:** one transaction per 3 cycles. Back-to-back requests alternate when both ports are held high.
- **Single-cycle strobe:** `valid*` is high for exactly one cycle. `valid0` and `valid1` are never high together.
- **Reset mid-transaction:** the in-flight read is discarded, no `valid` is produced, and all outputs return to reset values at that edge.
- **Error path:** `mem_error` is forwarded unmodified. `data` is still captured when `err` = 1.

## Test plan
ROM content for all scenarios: byte at address a = a; DW = 128.
- **Single fetch:** reset, then `req0`=1, `addr0`=3, `extra0`=0 → `valid0` high exactly 3 edges after `req0` is sampled; `data0[7:0]`=8'h03; `err0`=0; `valid1` stays 0.
- **Tie:** after reset, `req0`=`req1`=1 held, `addr0`=1, `addr1`=2 → strobes occur in the order `valid0`, `valid1`, `valid0`, `valid1`, spaced 3 cycles apart; `data1[7:0]`=8'h02.
- **Bounds fault:**
  - Step 1: `cfg_we`, `cfg_sel`=1, `cfg_lower`=0, `cfg_upper`=7; then `req1` with `addr1`=20 → `valid1`=1, `err1`=1.
  - Step 2: `req0` with `addr0`=20 → `err0`=0, `data0[7:0]`=8'h14.
- **Config during transaction:** write port-0 bounds to 0..3 in the ISSUE cycle of a port-0 read at `addr0`=10 → that read returns `err0`=0; the next read at 10 returns `err0`=1.
- **Reset mid-operation:** assert `reset` in ISSUE → no `valid` pulse, `busy`=0 next cycle, `mem_upper_bound`=all-ones. A subsequent request completes normally.
- **Hold rule:** `req1` held high through 2 strobes → exactly 2 `valid1` pulses 3 cycles apart; `req0` arriving mid-stream is granted next.
